// File: rtl/seq_addsub_16.sv
// -----------------------------------------------------------------------------
// seq_addsub_16
//
// Sequential 16-bit adder/subtractor that works one nibble per clock, LSB
// first. A request is taken only in IDLE. The block then spends four RUN
// cycles, one per nibble, rippling a single carry bit between them. After the
// last nibble it spends one DONE cycle and then returns to IDLE.
//
// Subtraction is a + ~b + 1. The initial carry is set to 'sub' and each
// b nibble is inverted with {4{sub}}. c_out is therefore the true carry out of
// bit 15, which in subtract mode means "no borrow".
//
// Ports
//   clk       in   system clock, all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   start     in   operation request, sampled only in IDLE
//   sub       in   0 = a+b, 1 = a-b, sampled with start
//   a, b      in   16-bit operands, sampled with start
//   busy      out  high exactly while in RUN
//   done      out  one-cycle completion pulse (the DONE state)
//   result    out  registered sum/difference, held between completions
//   c_out     out  carry out of bit 15
//   overflow  out  two's-complement overflow (carry into bit 15 ^ carry out)
//   zero      out  high when result == 0
// -----------------------------------------------------------------------------
module seq_addsub_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        c_out,
    output logic        overflow,
    output logic        zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] LAST_NIBBLE = 2'd3;

    // 5-bit nibble add: {carry_out, sum[3:0]}
    function automatic logic [4:0] nibble_add(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        nibble_add = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    endfunction

    // Pick nibble idx out of a 16-bit word
    function automatic logic [3:0] nibble_sel(
        input logic [15:0] w,
        input logic [1:0]  idx
    );
        case (idx)
            2'd0:    nibble_sel = w[3:0];
            2'd1:    nibble_sel = w[7:4];
            2'd2:    nibble_sel = w[11:8];
            2'd3:    nibble_sel = w[15:12];
            default: nibble_sel = 4'h0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        sub_r;
    logic        carry_r;
    logic [1:0]  cnt_r;
    logic [15:0] acc_r;

    logic        busy_r;
    logic        done_r;
    logic [15:0] result_r;
    logic        c_out_r;
    logic        overflow_r;
    logic        zero_r;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0]  state_nxt_s;
    logic [3:0]  nib_a_s;
    logic [3:0]  nib_b_s;
    logic [4:0]  nib_sum_s;
    logic [3:0]  low3_sum_s;
    logic        c15_in_s;
    logic        last_s;
    logic [15:0] final_s;
    logic        accept_s;

    // Accept a request only from IDLE; start in RUN/DONE is dropped, not queued
    assign accept_s = (state_r == IDLE) && start;
    assign last_s   = (state_r == RUN) && (cnt_r == LAST_NIBBLE);

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_NIBBLE) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Nibble datapath: add the current nibble pair with the rippled carry
    always_comb begin
        nib_a_s    = nibble_sel(a_r, cnt_r);
        nib_b_s    = nibble_sel(b_r, cnt_r) ^ {4{sub_r}};
        nib_sum_s  = nibble_add(nib_a_s, nib_b_s, carry_r);
        // Carry into bit 15 is the carry out of the low three bits of nibble 3;
        // only meaningful while cnt_r == 3, ignored otherwise.
        low3_sum_s = {1'b0, nib_a_s[2:0]} + {1'b0, nib_b_s[2:0]} + {3'b000, carry_r};
        c15_in_s   = low3_sum_s[3];
        // Top nibble goes straight into the result so the output can load on
        // the same edge that finishes the last nibble.
        final_s    = {nib_sum_s[3:0], acc_r[11:0]};
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state plus busy/done, both derived from the next state so they are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture on accept, then nibble-by-nibble carry/counter/accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= 16'h0000;
            b_r     <= 16'h0000;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cnt_r   <= 2'd0;
            acc_r   <= 16'h0000;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry_r <= sub;
            cnt_r   <= 2'd0;
        end else if (state_r == RUN) begin
            carry_r <= nib_sum_s[4];
            cnt_r   <= cnt_r + 2'd1;
            case (cnt_r)
                2'd0:    acc_r[3:0]   <= nib_sum_s[3:0];
                2'd1:    acc_r[7:4]   <= nib_sum_s[3:0];
                2'd2:    acc_r[11:8]  <= nib_sum_s[3:0];
                2'd3:    acc_r[15:12] <= nib_sum_s[3:0];
                default: acc_r        <= acc_r;
            endcase
        end else begin
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Visible results load only when the last nibble completes, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r   <= 16'h0000;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (last_s) begin
            result_r   <= final_s;
            c_out_r    <= nib_sum_s[4];
            overflow_r <= c15_in_s ^ nib_sum_s[4];
            zero_r     <= (final_s == 16'h0000);
        end else begin
            result_r   <= result_r;
            c_out_r    <= c_out_r;
            overflow_r <= overflow_r;
            zero_r     <= zero_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign c_out    = c_out_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: tb/tb_seq_addsub_16.sv
// -----------------------------------------------------------------------------
// tb_seq_addsub_16
//
// Self-checking bench for seq_addsub_16. Expected values come from a plain
// integer model (unsigned sum/difference for result and carry, signed range
// test for overflow). The bench also checks cycle timing: busy for E..E+4,
// done only in E+4..E+5, and outputs held during RUN.
// -----------------------------------------------------------------------------
module tb_seq_addsub_16;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c_out;
    logic        overflow;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    // last completed values (what the outputs must hold)
    logic [15:0] held_result = 16'h0000;
    logic        held_c      = 1'b0;
    logic        held_ov     = 1'b0;
    logic        held_z      = 1'b0;

    // expected values of the operation in flight
    logic [15:0] pend_result;
    logic        pend_c;
    logic        pend_ov;
    logic        pend_z;

    seq_addsub_16 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic
    task automatic model_op(input logic s, input logic [15:0] x, input logic [15:0] y);
        int          ux;
        int          uy;
        int          sx;
        int          sy;
        int          full_u;
        int          full_s;
        logic [31:0] bits;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            full_u = ux + uy;
            full_s = sx + sy;
            pend_c = (full_u >= 65536);
        end else begin
            full_u = ux - uy;
            full_s = sx - sy;
            pend_c = (ux >= uy);
        end
        bits        = full_u;
        pend_result = bits[15:0];
        pend_ov     = (full_s > 32767) || (full_s < -32768);
        pend_z      = (pend_result == 16'h0000);
    endtask

    task automatic check_hold(input string tag);
        check_val({tag, "_result"}, {16'h0, result}, {16'h0, held_result});
        check_val({tag, "_cout"}, {31'h0, c_out}, {31'h0, held_c});
        check_val({tag, "_ovf"}, {31'h0, overflow}, {31'h0, held_ov});
        check_val({tag, "_zero"}, {31'h0, zero}, {31'h0, held_z});
    endtask

    // One operation. preloaded: start/operands already driven by the caller.
    // repulse: keep start high with junk operands through RUN, then present
    // (ns, nx, ny) with start still high from DONE onward.
    task automatic run_op(input string tag, input logic s, input logic [15:0] x, input logic [15:0] y,
                          input bit preloaded, input bit repulse,
                          input logic ns, input logic [15:0] nx, input logic [15:0] ny);
        if (!preloaded) begin
            @(negedge clk);
            sub   = s;
            a     = x;
            b     = y;
            start = 1'b1;
        end
        model_op(s, x, y);
        @(posedge clk);  // edge E
        #1;
        start = repulse;
        a     = 16'($urandom());
        b     = 16'($urandom());
        sub   = 1'($urandom());
        check_val({tag, "_busyE"}, {31'h0, busy}, 32'd1);
        check_val({tag, "_doneE"}, {31'h0, done}, 32'd0);
        check_hold({tag, "_holdE"});
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (repulse) begin
                a   = 16'($urandom());
                b   = 16'($urandom());
                sub = 1'($urandom());
            end
            check_val({tag, "_busyR"}, {31'h0, busy}, 32'd1);
            check_val({tag, "_doneR"}, {31'h0, done}, 32'd0);
            check_hold({tag, "_holdR"});
        end
        @(posedge clk);  // edge E+4
        #1;
        check_val({tag, "_busy4"}, {31'h0, busy}, 32'd0);
        check_val({tag, "_done4"}, {31'h0, done}, 32'd1);
        held_result = pend_result;
        held_c      = pend_c;
        held_ov     = pend_ov;
        held_z      = pend_z;
        check_hold({tag, "_res"});
        if (repulse) begin
            a     = nx;
            b     = ny;
            sub   = ns;
            start = 1'b1;
        end
        @(posedge clk);  // edge E+5, still DONE: start must be ignored
        #1;
        check_val({tag, "_busy5"}, {31'h0, busy}, 32'd0);
        check_val({tag, "_done5"}, {31'h0, done}, 32'd0);
        check_hold({tag, "_hold5"});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {31'h0, busy}, 32'd0);
        check_val("rst_done", {31'h0, done}, 32'd0);
        check_hold("rst");
        reset = 1'b0;

        // directed cases
        run_op("add_4_5", 1'b0, 16'h0004, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("add_4_5_val", {16'h0, held_result}, 32'h0009);
        run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("sub_a_6", 1'b1, 16'h000A, 16'h0006, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // start re-pulsed during RUN, held through DONE, accepted at first IDLE
        run_op("repulse", 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h5555, 16'h1234);
        run_op("repulse_next", 1'b1, 16'h5555, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        // reset at E+2 aborts the add
        @(negedge clk);
        sub   = 1'b0;
        a     = 16'h1234;
        b     = 16'h4321;
        start = 1'b1;
        @(posedge clk);  // E
        #1;
        start = 1'b0;
        @(posedge clk);  // E+1
        #1;
        reset = 1'b1;
        @(posedge clk);  // E+2
        #1;
        reset       = 1'b0;
        held_result = 16'h0000;
        held_c      = 1'b0;
        held_ov     = 1'b0;
        held_z      = 1'b0;
        check_val("abort_busy", {31'h0, busy}, 32'd0);
        check_val("abort_done", {31'h0, done}, 32'd0);
        check_hold("abort");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_val("abort_nodone", {31'h0, done}, 32'd0);
            check_val("abort_nobusy", {31'h0, busy}, 32'd0);
        end
        run_op("after_abort", 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_val("after_abort_val", {16'h0, held_result}, 32'h0007);

        // reset wins over start in the same cycle
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        held_result = 16'h0000;
        held_c      = 1'b0;
        held_ov     = 1'b0;
        held_z      = 1'b0;
        check_val("rst_dom_busy", {31'h0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_dom_busy2", {31'h0, busy}, 32'd0);
        check_hold("rst_dom");

        // randomized operations, with a bias toward corner operands
        for (int i = 0; i < 40; i++) begin
            logic [15:0] rx;
            logic [15:0] ry;
            rx = 16'($urandom());
            ry = 16'($urandom());
            if (i % 8 == 1) rx = 16'h8000;
            if (i % 8 == 2) ry = 16'h7FFF;
            if (i % 8 == 3) ry = rx;
            run_op("rand", 1'($urandom()), rx, ry, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_addsub_16.md
SEQ_ADDSUB_16 -- requirements
Module: seq_addsub_16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 The block SHALL have port `clk`: input, 1 bit, system clock.
REQ-003 The block SHALL have port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port `start`: input, 1 bit, operation request, sampled only in IDLE.
REQ-005 The block SHALL have port `sub`: input, 1 bit, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have port `a`: input, 16 bits, operand A; sampled with start.
REQ-007 The block SHALL have port `b`: input, 16 bits, operand B; sampled with start.
REQ-008 The block SHALL have port `busy`: output, 1 bit, high while in RUN.
REQ-009 The block SHALL have port `done`: output, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have port `result`: output, 16 bits, registered sum or difference.
REQ-011 The block SHALL have port `c_out`: output, 1 bit, carry out of bit 15 (in sub mode, 1 = no borrow).
REQ-012 The block SHALL have port `overflow`: output, 1 bit, two's-complement signed overflow.
REQ-013 The block SHALL have port `zero`: output, 1 bit, high when result == 0.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and sub, set the internal carry to sub, clear the 2-bit nibble counter, and enter RUN.
REQ-016 Each RUN cycle SHALL process one nibble n, LSB first: s = a[4n+3:4n] + (b[4n+3:4n] XOR {4{sub}}) + carry.
- The 4-bit result SHALL be written to the internal accumulator.
- The carry SHALL be updated.
- The counter SHALL be incremented.
REQ-017 During nibble 3, the block SHALL capture both the carry into bit 15 and the carry out of bit 15.
REQ-018 After nibble 3, the block SHALL move to DONE.
- result, c_out, zero and overflow (carry-in of bit 15 XOR carry-out of bit 15) SHALL load on that same edge.
- done SHALL go high on that same edge.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 Latency: if start is sampled at edge E, done SHALL be high in the cycle from E+4 to E+5, and low at all other times.
REQ-021 busy SHALL be 1 exactly in RUN, i.e. the four cycles from E to E+4.
REQ-022 start SHALL be ignored in RUN and DONE, including any operand or sub changes, and SHALL NOT be queued.
REQ-023 Back-to-back operation: a start held high through DONE SHALL be accepted in the following IDLE cycle, so the minimum issue interval is 6 cycles.
REQ-024 result, c_out, overflow and zero SHALL hold their last completed values from DONE until the next completion; they SHALL NOT show partial values during RUN.
REQ-025 Arithmetic SHALL be modulo 2^16, and no output SHALL be wider than specified.

Reset
REQ-026 On reset=1 the block SHALL enter IDLE and set busy, done, result, c_out, overflow and zero all to 0 on the next edge.
REQ-027 reset SHALL dominate start in the same cycle.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse.
- The first start after reset deasserts SHALL be handled normally.

Verification
REQ-029 The bench SHALL cover add 0x0004 + 0x0005.
- Required response: done at E+4, result 0x0009, c_out 0, overflow 0, zero 0.
- busy SHALL be high for exactly 4 cycles.
REQ-030 The bench SHALL cover add 0xFFFF + 0x0001.
- Required response: result 0x0000, c_out 1, zero 1, overflow 0.
REQ-031 The bench SHALL cover sub 0x0005 - 0x0007 and sub 0x000A - 0x0006.
- First: result 0xFFFE, c_out 0, overflow 0.
- Second: result 0x0004, c_out 1.
REQ-032 The bench SHALL cover add 0x7FFF + 0x0001 and sub 0x8000 - 0x0001.
- First: result 0x8000, overflow 1.
- Second: result 0x7FFF, overflow 1, c_out 1.
REQ-033 The bench SHALL cover a start re-pulse during RUN with a=0x1234 and b=0x1111.
- Required response: result reflects only the first operation; exactly one done pulse; the next start is accepted at the first IDLE cycle.
REQ-034 The bench SHALL cover reset asserted at E+2 of an add.
- Required response: next cycle all outputs 0 and busy 0; no done; a subsequent 0x0003 + 0x0004 yields 0x0007.
